// File: rtl/int_alu_pipe.sv
// Handshaked integer ALU: single-cycle ops plus an iterative signed divider,
// with a tagged output register that holds its result under back-pressure.
module int_alu_pipe #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OPCODE_WIDTH = 8,
    parameter int unsigned TAG_WIDTH    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]   operand_a,
    input  logic [DATA_WIDTH-1:0]   operand_b,
    input  logic                    use_immediate,
    input  logic [DATA_WIDTH-1:0]   immediate_value,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   result_out,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    carry_out,
    output logic                    overflow_out,
    output logic                    illegal_out
);

    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    localparam logic [OPCODE_WIDTH-1:0] OpAdd    = OPCODE_WIDTH'(8'h01);
    localparam logic [OPCODE_WIDTH-1:0] OpSub    = OPCODE_WIDTH'(8'h02);
    localparam logic [OPCODE_WIDTH-1:0] OpMul    = OPCODE_WIDTH'(8'h03);
    localparam logic [OPCODE_WIDTH-1:0] OpDiv    = OPCODE_WIDTH'(8'h04);
    localparam logic [OPCODE_WIDTH-1:0] OpNeg    = OPCODE_WIDTH'(8'h05);
    localparam logic [OPCODE_WIDTH-1:0] OpAbs    = OPCODE_WIDTH'(8'h06);
    localparam logic [OPCODE_WIDTH-1:0] OpRem    = OPCODE_WIDTH'(8'h07);
    localparam logic [OPCODE_WIDTH-1:0] OpAnd    = OPCODE_WIDTH'(8'h20);
    localparam logic [OPCODE_WIDTH-1:0] OpOr     = OPCODE_WIDTH'(8'h21);
    localparam logic [OPCODE_WIDTH-1:0] OpXor    = OPCODE_WIDTH'(8'h22);
    localparam logic [OPCODE_WIDTH-1:0] OpNot    = OPCODE_WIDTH'(8'h23);
    localparam logic [OPCODE_WIDTH-1:0] OpNor    = OPCODE_WIDTH'(8'h24);
    localparam logic [OPCODE_WIDTH-1:0] OpShl    = OPCODE_WIDTH'(8'h30);
    localparam logic [OPCODE_WIDTH-1:0] OpShr    = OPCODE_WIDTH'(8'h31);
    localparam logic [OPCODE_WIDTH-1:0] OpRotl   = OPCODE_WIDTH'(8'h32);
    localparam logic [OPCODE_WIDTH-1:0] OpRotr   = OPCODE_WIDTH'(8'h33);
    localparam logic [OPCODE_WIDTH-1:0] OpAsr    = OPCODE_WIDTH'(8'h34);
    localparam logic [OPCODE_WIDTH-1:0] OpEq     = OPCODE_WIDTH'(8'h40);
    localparam logic [OPCODE_WIDTH-1:0] OpNe     = OPCODE_WIDTH'(8'h41);
    localparam logic [OPCODE_WIDTH-1:0] OpLt     = OPCODE_WIDTH'(8'h42);
    localparam logic [OPCODE_WIDTH-1:0] OpLe     = OPCODE_WIDTH'(8'h43);
    localparam logic [OPCODE_WIDTH-1:0] OpGt     = OPCODE_WIDTH'(8'h44);
    localparam logic [OPCODE_WIDTH-1:0] OpGe     = OPCODE_WIDTH'(8'h45);
    localparam logic [OPCODE_WIDTH-1:0] OpLtu    = OPCODE_WIDTH'(8'h46);
    localparam logic [OPCODE_WIDTH-1:0] OpLeu    = OPCODE_WIDTH'(8'h47);
    localparam logic [OPCODE_WIDTH-1:0] OpGtu    = OPCODE_WIDTH'(8'h48);
    localparam logic [OPCODE_WIDTH-1:0] OpGeu    = OPCODE_WIDTH'(8'h49);
    localparam logic [OPCODE_WIDTH-1:0] OpMins   = OPCODE_WIDTH'(8'h60);
    localparam logic [OPCODE_WIDTH-1:0] OpMaxs   = OPCODE_WIDTH'(8'h61);
    localparam logic [OPCODE_WIDTH-1:0] OpMinu   = OPCODE_WIDTH'(8'h62);
    localparam logic [OPCODE_WIDTH-1:0] OpMaxu   = OPCODE_WIDTH'(8'h63);
    localparam logic [OPCODE_WIDTH-1:0] OpClz    = OPCODE_WIDTH'(8'h71);
    localparam logic [OPCODE_WIDTH-1:0] OpPopc   = OPCODE_WIDTH'(8'h72);
    localparam logic [OPCODE_WIDTH-1:0] OpAddsat = OPCODE_WIDTH'(8'h80);
    localparam logic [OPCODE_WIDTH-1:0] OpSubsat = OPCODE_WIDTH'(8'h81);
    localparam logic [OPCODE_WIDTH-1:0] OpAddcc  = OPCODE_WIDTH'(8'h90);
    localparam logic [OPCODE_WIDTH-1:0] OpSubcc  = OPCODE_WIDTH'(8'h91);
    localparam logic [OPCODE_WIDTH-1:0] OpMulcc  = OPCODE_WIDTH'(8'h92);

    localparam logic [DATA_WIDTH-1:0] MinVal  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MaxVal  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OnesVal = {DATA_WIDTH{1'b1}};
    localparam logic [SHW-1:0]        LastIt  = SHW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

    state_e state_q, state_d;

    // Output register
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic [TAG_WIDTH-1:0]  tag_out_q;
    logic                  carry_q, ovf_q, ill_q;

    // Divider state
    logic [DATA_WIDTH-1:0] a_q, dvd_q, dvsr_q, rem_q;
    logic [SHW-1:0]        cnt_q;
    logic                  q_neg_q, r_neg_q, is_rem_q, dz_q, dovf_q;
    logic [TAG_WIDTH-1:0]  div_tag_q;

    logic                  accept, is_div_op, out_free, fix_load;
    logic [DATA_WIDTH-1:0] b_eff, a_mag, b_mag;
    logic [SHW-1:0]        sh;
    logic [DATA_WIDTH:0]   add_w, sub_w, div_sh, div_diff;
    logic [2*DATA_WIDTH-1:0] prod;
    logic                  add_ovf, sub_ovf, lts, ltu, eq;
    logic [SHW:0]          clz_cnt, popc_cnt;
    logic [DATA_WIDTH-1:0] alu_res, fix_res, q_fix, r_fix;
    logic                  alu_c, alu_v, alu_ill, fix_v;

    assign b_eff     = use_immediate ? immediate_value : operand_b;
    assign accept    = in_valid && in_ready;
    assign is_div_op = (opcode == OpDiv) || (opcode == OpRem);
    assign out_free  = !out_valid_q || out_ready;
    assign sh        = b_eff[SHW-1:0];

    assign add_w   = {1'b0, operand_a} + {1'b0, b_eff};
    assign sub_w   = {1'b0, operand_a} - {1'b0, b_eff};
    assign prod    = {{DATA_WIDTH{operand_a[DATA_WIDTH-1]}}, operand_a} *
                     {{DATA_WIDTH{b_eff[DATA_WIDTH-1]}}, b_eff};
    assign add_ovf = (operand_a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                     (add_w[DATA_WIDTH-1] != operand_a[DATA_WIDTH-1]);
    assign sub_ovf = (operand_a[DATA_WIDTH-1] != b_eff[DATA_WIDTH-1]) &&
                     (sub_w[DATA_WIDTH-1] != operand_a[DATA_WIDTH-1]);
    assign lts     = $signed(operand_a) < $signed(b_eff);
    assign ltu     = operand_a < b_eff;
    assign eq      = operand_a == b_eff;

    // MIN's magnitude is 2^(W-1), which is exactly MIN's bit pattern unsigned
    assign a_mag = operand_a[DATA_WIDTH-1] ? -operand_a : operand_a;
    assign b_mag = b_eff[DATA_WIDTH-1] ? -b_eff : b_eff;

    // Restoring divide step: shift in next dividend bit, subtract if it fits
    assign div_sh   = {rem_q, dvd_q[DATA_WIDTH-1]};
    assign div_diff = div_sh - {1'b0, dvsr_q};

    // Leading-zero and population counts of operand A
    always_comb begin
        clz_cnt  = (SHW+1)'(DATA_WIDTH);
        popc_cnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (operand_a[i]) clz_cnt = (SHW+1)'(DATA_WIDTH - 1 - i);
            popc_cnt = popc_cnt + (SHW+1)'(operand_a[i]);
        end
    end

    // Single-cycle result and flags
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (opcode)
            OpAdd:    alu_res = add_w[DATA_WIDTH-1:0];
            OpSub:    alu_res = sub_w[DATA_WIDTH-1:0];
            OpMul:    alu_res = prod[DATA_WIDTH-1:0];
            OpNeg:    alu_res = -operand_a;
            OpAbs: begin
                alu_res = a_mag;
                alu_v   = (operand_a == MinVal);
            end
            OpAnd:    alu_res = operand_a & b_eff;
            OpOr:     alu_res = operand_a | b_eff;
            OpXor:    alu_res = operand_a ^ b_eff;
            OpNot:    alu_res = ~operand_a;
            OpNor:    alu_res = ~(operand_a | b_eff);
            OpShl:    alu_res = operand_a << sh;
            OpShr:    alu_res = operand_a >> sh;
            // A shift by DATA_WIDTH yields 0, so rotate by 0 returns A
            OpRotl:   alu_res = (operand_a << sh) | (operand_a >> (DATA_WIDTH - sh));
            OpRotr:   alu_res = (operand_a >> sh) | (operand_a << (DATA_WIDTH - sh));
            OpAsr:    alu_res = $signed(operand_a) >>> sh;
            OpEq:     alu_res = {DATA_WIDTH{eq}};
            OpNe:     alu_res = {DATA_WIDTH{!eq}};
            OpLt:     alu_res = {DATA_WIDTH{lts}};
            OpLe:     alu_res = {DATA_WIDTH{lts || eq}};
            OpGt:     alu_res = {DATA_WIDTH{!lts && !eq}};
            OpGe:     alu_res = {DATA_WIDTH{!lts}};
            OpLtu:    alu_res = {DATA_WIDTH{ltu}};
            OpLeu:    alu_res = {DATA_WIDTH{ltu || eq}};
            OpGtu:    alu_res = {DATA_WIDTH{!ltu && !eq}};
            OpGeu:    alu_res = {DATA_WIDTH{!ltu}};
            OpMins:   alu_res = lts ? operand_a : b_eff;
            OpMaxs:   alu_res = lts ? b_eff : operand_a;
            OpMinu:   alu_res = ltu ? operand_a : b_eff;
            OpMaxu:   alu_res = ltu ? b_eff : operand_a;
            OpClz:    alu_res = DATA_WIDTH'(clz_cnt);
            OpPopc:   alu_res = DATA_WIDTH'(popc_cnt);
            OpAddsat: begin
                alu_res = add_ovf ? (operand_a[DATA_WIDTH-1] ? MinVal : MaxVal)
                                  : add_w[DATA_WIDTH-1:0];
                alu_v   = add_ovf;
            end
            OpSubsat: begin
                alu_res = sub_ovf ? (operand_a[DATA_WIDTH-1] ? MinVal : MaxVal)
                                  : sub_w[DATA_WIDTH-1:0];
                alu_v   = sub_ovf;
            end
            OpAddcc: begin
                alu_res = add_w[DATA_WIDTH-1:0];
                alu_c   = add_w[DATA_WIDTH];
            end
            OpSubcc: begin
                alu_res = sub_w[DATA_WIDTH-1:0];
                alu_c   = sub_w[DATA_WIDTH];
            end
            OpMulcc: begin
                alu_res = prod[DATA_WIDTH-1:0];
                alu_v   = prod[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{prod[DATA_WIDTH-1]}};
            end
            OpDiv, OpRem: alu_res = '0;
            default:  alu_ill = 1'b1;
        endcase
    end

    // Sign correction and special cases for the divider result
    always_comb begin
        q_fix   = q_neg_q ? -dvd_q : dvd_q;
        r_fix   = r_neg_q ? -rem_q : rem_q;
        fix_res = is_rem_q ? r_fix : q_fix;
        fix_v   = 1'b0;
        if (dz_q) begin
            fix_res = is_rem_q ? a_q : OnesVal;
        end else if (dovf_q) begin
            fix_res = is_rem_q ? '0 : MinVal;
            fix_v   = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && is_div_op) state_d = StDiv;
            StDiv:   if (cnt_q == LastIt) state_d = StFix;
            StFix:   if (out_free) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready = !rst && (state_q == StIdle) && out_free;
        fix_load = (state_q == StFix) && out_free;
    end

    // Divider datapath: capture operands at acceptance, iterate in StDiv
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            dvd_q     <= '0;
            dvsr_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            is_rem_q  <= 1'b0;
            dz_q      <= 1'b0;
            dovf_q    <= 1'b0;
            div_tag_q <= '0;
        end else if (accept && is_div_op) begin
            a_q       <= operand_a;
            dvd_q     <= a_mag;
            dvsr_q    <= b_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= operand_a[DATA_WIDTH-1] ^ b_eff[DATA_WIDTH-1];
            r_neg_q   <= operand_a[DATA_WIDTH-1];
            is_rem_q  <= (opcode == OpRem);
            dz_q      <= (b_eff == '0);
            dovf_q    <= (operand_a == MinVal) && (b_eff == OnesVal);
            div_tag_q <= in_tag;
        end else if (state_q == StDiv) begin
            rem_q <= div_diff[DATA_WIDTH] ? div_sh[DATA_WIDTH-1:0] : div_diff[DATA_WIDTH-1:0];
            dvd_q <= {dvd_q[DATA_WIDTH-2:0], !div_diff[DATA_WIDTH]};
            cnt_q <= cnt_q + SHW'(1);
        end
    end

    // Output register: load on single-cycle accept or divider fix, clear on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            tag_out_q   <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else if (accept && !is_div_op) begin
            out_valid_q <= 1'b1;
            res_q       <= alu_res;
            tag_out_q   <= in_tag;
            carry_q     <= alu_c;
            ovf_q       <= alu_v;
            ill_q       <= alu_ill;
        end else if (fix_load) begin
            out_valid_q <= 1'b1;
            res_q       <= fix_res;
            tag_out_q   <= div_tag_q;
            carry_q     <= 1'b0;
            ovf_q       <= fix_v;
            ill_q       <= 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign result_out   = res_q;
    assign out_tag      = tag_out_q;
    assign carry_out    = carry_q;
    assign overflow_out = ovf_q;
    assign illegal_out  = ill_q;

endmodule

// File: tb/tb_int_alu_pipe.sv
// Scoreboard bench for int_alu_pipe: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_int_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [7:0]  opcode;
    logic [31:0] operand_a, operand_b, immediate_value;
    logic        use_immediate;
    logic [5:0]  in_tag;
    logic        out_valid, out_ready;
    logic [31:0] result_out;
    logic [5:0]  out_tag;
    logic        carry_out, overflow_out, illegal_out;

    int_alu_pipe #(
        .DATA_WIDTH  (32),
        .OPCODE_WIDTH(8),
        .TAG_WIDTH   (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .opcode         (opcode),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .use_immediate  (use_immediate),
        .immediate_value(immediate_value),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result_out     (result_out),
        .out_tag        (out_tag),
        .carry_out      (carry_out),
        .overflow_out   (overflow_out),
        .illegal_out    (illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
        logic        c;
        logic        v;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_ctl = 1;  // 0: hold low, 1: hold high, 2: random
    logic seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_ctl == 0)      out_ready = 1'b0;
            else if (ready_ctl == 1) out_ready = 1'b1;
            else                     out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [5:0] tag);
        exp_t        m;
        int          sa, sbv, s;
        longint      ls;
        logic [63:0] lu;
        sa  = int'(a);
        sbv = int'(b);
        s   = int'(b[4:0]);
        m.res = '0; m.tag = tag; m.c = 1'b0; m.v = 1'b0; m.ill = 1'b0; m.cyc = 0;
        case (op)
            8'h01: m.res = a + b;
            8'h02: m.res = a - b;
            8'h03: m.res = a * b;
            8'h05: m.res = -sa;
            8'h06: if (a == 32'h8000_0000) begin m.res = a; m.v = 1'b1; end
                   else m.res = (sa < 0) ? -sa : sa;
            8'h20: m.res = a & b;
            8'h21: m.res = a | b;
            8'h22: m.res = a ^ b;
            8'h23: m.res = ~a;
            8'h24: m.res = ~(a | b);
            8'h30: m.res = a << s;
            8'h31: m.res = a >> s;
            8'h32: m.res = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            8'h33: m.res = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            8'h34: m.res = sa >>> s;
            8'h40: m.res = (a == b) ? '1 : '0;
            8'h41: m.res = (a != b) ? '1 : '0;
            8'h42: m.res = (sa < sbv) ? '1 : '0;
            8'h43: m.res = (sa <= sbv) ? '1 : '0;
            8'h44: m.res = (sa > sbv) ? '1 : '0;
            8'h45: m.res = (sa >= sbv) ? '1 : '0;
            8'h46: m.res = (a < b) ? '1 : '0;
            8'h47: m.res = (a <= b) ? '1 : '0;
            8'h48: m.res = (a > b) ? '1 : '0;
            8'h49: m.res = (a >= b) ? '1 : '0;
            8'h60: m.res = (sa < sbv) ? a : b;
            8'h61: m.res = (sa > sbv) ? a : b;
            8'h62: m.res = (a < b) ? a : b;
            8'h63: m.res = (a > b) ? a : b;
            8'h71: begin
                m.res = 32;
                for (int i = 31; i >= 0; i--) if (a[i]) begin m.res = 31 - i; break; end
            end
            8'h72: m.res = $countones(a);
            8'h80, 8'h81: begin
                ls = (op == 8'h80) ? longint'(sa) + longint'(sbv) : longint'(sa) - longint'(sbv);
                if (ls > 64'sh7FFF_FFFF)        begin m.res = 32'h7FFF_FFFF; m.v = 1'b1; end
                else if (ls < -64'sh8000_0000)  begin m.res = 32'h8000_0000; m.v = 1'b1; end
                else m.res = ls[31:0];
            end
            8'h90: begin lu = {32'b0, a} + {32'b0, b}; m.res = lu[31:0]; m.c = lu[32]; end
            8'h91: begin m.res = a - b; m.c = (a < b); end
            8'h92: begin
                ls = longint'(sa) * longint'(sbv);
                m.res = ls[31:0];
                m.v = (ls != longint'(int'(ls[31:0])));
            end
            8'h04, 8'h07: begin
                if (b == 0) m.res = (op == 8'h04) ? 32'hFFFF_FFFF : a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m.res = (op == 8'h04) ? 32'h8000_0000 : 32'h0;
                    m.v = 1'b1;
                end else m.res = (op == 8'h04) ? sa / sbv : sa % sbv;
            end
            default: m.ill = 1'b1;
        endcase
        return m;
    endfunction

    // Monitor: first sighting checks latency, transfer checks payload
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_valid=1 tag %h, required no output", out_tag);
            end else begin
                e = exp_q[0];
                if (!seen) begin
                    chk("latency", cyc, e.cyc);
                    seen = 1'b1;
                end
                if (out_ready) begin
                    chk("result", result_out, e.res);
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    chk("carry", 32'(carry_out), 32'(e.c));
                    chk("overflow", 32'(overflow_out), 32'(e.v));
                    chk("illegal", 32'(illegal_out), 32'(e.ill));
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Present one instruction, wait for acceptance, push its expectation.
    // acc returns the cycle number right after the accepting edge.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ui, input logic [31:0] imm, input logic [5:0] tag,
                         output int acc);
        exp_t e;
        int   n = 0;
        acc = -1;
        opcode = op; operand_a = a; operand_b = b;
        use_immediate = ui; immediate_value = imm; in_tag = tag; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
                in_valid = 1'b0;
                return;
            end
        end
        e = model(op, a, ui ? imm : b, tag);
        acc = cyc + 1;
        e.cyc = acc + (((op == 8'h04) || (op == 8'h07)) ? 33 : 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs to show operands were captured at acceptance
        opcode = 8'($urandom); operand_a = $urandom; operand_b = $urandom;
        immediate_value = $urandom; in_tag = 6'($urandom); use_immediate = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int acc, acc1, acc2, acc3, n;
        logic [7:0] ops[39];
        ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h20, 8'h21, 8'h22,
                8'h23, 8'h24, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h40, 8'h41, 8'h42,
                8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h60, 8'h61, 8'h62,
                8'h63, 8'h71, 8'h72, 8'h80, 8'h81, 8'h90, 8'h91, 8'h92, 8'h0A};

        rst = 1'b1; in_valid = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
        use_immediate = 1'b0; immediate_value = '0; in_tag = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_flags", {29'd0, carry_out, overflow_out, illegal_out}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // ADD / ADDSAT overflow boundary
        issue(8'h01, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0, 6'd5, acc);
        issue(8'h80, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0, 6'd6, acc);

        // Back-to-back carries and ASR
        issue(8'h90, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 6'd10, acc1);
        issue(8'h91, 32'h1, 32'h2, 1'b0, 32'h0, 6'd11, acc2);
        issue(8'h34, 32'h8000_0000, 32'h0, 1'b1, 32'h4, 6'd12, acc3);
        chk("b2b_accept_1", 32'(acc2), 32'(acc1 + 1));
        chk("b2b_accept_2", 32'(acc3), 32'(acc2 + 1));
        drain();

        // DIV / REM latency with in_ready low throughout
        for (int k = 0; k < 2; k++) begin
            issue(k == 0 ? 8'h04 : 8'h07, 32'hFFFF_FFF9, 32'h2, 1'(k), 32'h2, 6'(20 + k), acc);
            n = 0;
            forever begin
                @(negedge clk);
                if (out_valid || n > 100) break;
                chk("div_in_ready_low", 32'(in_ready), 32'd0);
                n++;
            end
            chk("div_latency", 32'(cyc - acc), 32'd33);
            @(posedge clk); #1;
        end

        // Divider special cases
        issue(8'h04, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 6'd30, acc);
        issue(8'h04, 32'd5, 32'd0, 1'b0, 32'h0, 6'd31, acc);
        issue(8'h07, 32'd5, 32'd0, 1'b0, 32'h0, 6'd32, acc);
        issue(8'h07, 32'h8000_0000, 32'h1234, 1'b1, 32'hFFFF_FFFF, 6'd33, acc);
        drain();

        // Back-pressure hold on CLZ
        ready_ctl = 0;
        issue(8'h71, 32'h0001_0000, 32'h0, 1'b0, 32'h0, 6'd9, acc);
        repeat (4) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result_out, 32'd15);
            chk("hold_tag", 32'(out_tag), 32'd9);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        ready_ctl = 1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Illegal opcode and CLZ of zero
        issue(8'hFF, 32'h1234_5678, 32'h9, 1'b0, 32'h0, 6'd40, acc);
        issue(8'h71, 32'h0, 32'h0, 1'b0, 32'h0, 6'd41, acc);
        drain();

        // Reset mid-divide: no result may emerge
        issue(8'h04, 32'd1000, 32'd7, 1'b0, 32'h0, 6'd50, acc);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("no_div_after_reset", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        issue(8'h01, 32'd3, 32'd4, 1'b0, 32'h0, 6'd51, acc);
        drain();

        // Randomized traffic with random back-pressure
        ready_ctl = 2;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] op;
            op = ($urandom_range(0, 19) == 0) ? 8'($urandom) : ops[$urandom_range(0, 38)];
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            issue(op, rval(), rval(), 1'($urandom), rval(), 6'($urandom), acc);
        end
        drain();
        ready_ctl = 1;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
